interrupt_controller: RTL and testbench

- Upstream of the CPU control unit. Collects 7 external interrupt request lines, latches their rising edges as pending, applies a software-programmable mask and prioritises the result.
- Presents one request at a time on interrupt_en/interrupt_num and holds it until the CPU returns from the handler, signalled by interrupt_ack.
- Software reaches the mask and pending registers through a small config port, mapped by the system bus decoder.

---
 rtl/interrupt_controller.sv | 166 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module  : interrupt_controller
// Brief   : 7-line edge-latched, masked, fixed-priority interrupt controller
//           with CPU request/ack handshake and a small config register port.
// Revision: 1.0
// ============================================================================
module interrupt_controller #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] RESET_MASK  = 7'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  irq_in,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        cfg_we,
    input  logic        cfg_re,
    output logic [15:0] cfg_rdata,
    output logic        interrupt_en,
    output logic [2:0]  interrupt_num,
    input  logic        interrupt_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    localparam logic [1:0] c_ADDR_MASK    = 2'd0;
    localparam logic [1:0] c_ADDR_PENDING = 2'd1;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd2;

    logic [SYNC_STAGES-1:0][6:0] r_sync;
    logic [6:0]  r_prev;
    logic [6:0]  r_pending;
    logic [6:0]  r_mask;
    logic        r_ack_d;
    state_t      r_state;
    logic [2:0]  r_cur;
    logic        r_en;
    logic [2:0]  r_num;
    logic        r_drain_done;
    logic [15:0] r_rdata;

    logic [6:0]  w_sync;
    logic [6:0]  w_rise;
    logic [6:0]  w_elig;
    logic        w_any;
    logic [2:0]  w_win;
    logic        w_ack_rise;
    logic [6:0]  w_w1c;
    logic [6:0]  w_ack_clr;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^cfg_wdata[15:7];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_ack_d <= 1'b0;
        end else begin
            r_sync[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev  <= w_sync;
            r_ack_d <= interrupt_ack;
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync & ~r_prev;
    assign w_elig     = r_pending & r_mask;
    assign w_any      = |w_elig;
    assign w_ack_rise = interrupt_ack & ~r_ack_d;
    assign w_w1c      = (cfg_we && cfg_addr == c_ADDR_PENDING) ? cfg_wdata[6:0] : 7'd0;
    assign w_ack_clr  = (r_state == S_ACTIVE && w_ack_rise) ? (7'd1 << r_cur) : 7'd0;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_win = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 3'(i);
            end
        end
    end

    // A fresh edge always beats a same-cycle clear so no request is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
            r_mask    <= RESET_MASK;
        end else begin
            r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_rise;
            if (cfg_we && cfg_addr == c_ADDR_MASK) begin
                r_mask <= cfg_wdata[6:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cur        <= 3'd0;
            r_en         <= 1'b0;
            r_num        <= 3'd0;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur   <= w_win;
                        r_num   <= w_win + 3'd1;
                        r_en    <= 1'b1;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_ack_rise) begin
                        r_en         <= 1'b0;
                        r_num        <= 3'd0;
                        r_drain_done <= 1'b0;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // One idle cycle after ack falls lets the CPU finish its bank switch.
                    if (!interrupt_ack) begin
                        if (r_drain_done) begin
                            r_drain_done <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_drain_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (cfg_re) begin
            case (cfg_addr)
                c_ADDR_MASK:    r_rdata <= {9'd0, r_mask};
                c_ADDR_PENDING: r_rdata <= {9'd0, r_pending};
                c_ADDR_STATUS:  r_rdata <= {10'd0, r_state, r_en, r_num};
                default:        r_rdata <= '0;
            endcase
        end
    end

    assign cfg_rdata     = r_rdata;
    assign interrupt_en  = r_en;
    assign interrupt_num = r_num;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_interrupt_controller
// Brief   : Directed self-checking bench for interrupt_controller.
// Revision: 1.0
// ============================================================================
module tb_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [6:0]  irq_in;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_we;
    logic        cfg_re;
    logic [15:0] cfg_rdata;
    logic        interrupt_en;
    logic [2:0]  interrupt_num;
    logic        interrupt_ack;

    int errors = 0;
    int checks = 0;
    logic [15:0] rd;

    interrupt_controller #(
        .SYNC_STAGES(2),
        .RESET_MASK (7'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_we       (cfg_we),
        .cfg_re       (cfg_re),
        .cfg_rdata    (cfg_rdata),
        .interrupt_en (interrupt_en),
        .interrupt_num(interrupt_num),
        .interrupt_ack(interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step(1);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
        cfg_re = 1'b1; cfg_addr = a;
        step(1);
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic wait_en(input string tag, input int max_cycles);
        int n = 0;
        while (interrupt_en !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check(tag, 16'(interrupt_en), 16'h0001);
    endtask

    task automatic ack_pulse(input int n);
        interrupt_ack = 1'b1;
        step(n);
        interrupt_ack = 1'b0;
        step(3);
    endtask

    task automatic pulse_irq(input logic [6:0] bits);
        irq_in = bits;
        step(1);
        irq_in = '0;
    endtask

    initial begin
        rst = 1'b0; irq_in = '0; cfg_addr = '0; cfg_wdata = '0;
        cfg_we = 1'b0; cfg_re = 1'b0; interrupt_ack = 1'b0;
        step(3);
        check("rst_en",    16'(interrupt_en),  16'h0000);
        check("rst_num",   16'(interrupt_num), 16'h0000);
        check("rst_rdata", cfg_rdata,          16'h0000);
        rst = 1'b1;
        step(1);
        cfg_read(2'd0, rd); check("rst_mask",    rd, 16'h0000);
        cfg_read(2'd1, rd); check("rst_pending", rd, 16'h0000);
        cfg_read(2'd2, rd); check("rst_status",  rd, 16'h0000);

        // Upper mask bits are not writable.
        cfg_write(2'd0, 16'hFFFF);
        cfg_read(2'd0, rd); check("mask_upper", rd, 16'h007F);
        cfg_read(2'd3, rd); check("addr3_read", rd, 16'h0000);
        // Simultaneous read and write returns the old value.
        cfg_re = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h0011;
        step(1);
        cfg_re = 1'b0; cfg_we = 1'b0;
        check("rw_same_cycle", cfg_rdata, 16'h007F);
        cfg_read(2'd0, rd); check("rw_new_value", rd, 16'h0011);
        cfg_write(2'd0, 16'h007F);

        // Test 1: latency and first request.
        pulse_irq(7'h04);
        step(1);
        cfg_re = 1'b1; cfg_addr = 2'd1;
        step(1);
        check("t1_pend_early", cfg_rdata,        16'h0000);
        check("t1_en_early",   16'(interrupt_en), 16'h0000);
        step(1);
        cfg_re = 1'b0;
        check("t1_pend",  cfg_rdata,          16'h0004);
        check("t1_en",    16'(interrupt_en),  16'h0001);
        check("t1_num",   16'(interrupt_num), 16'h0003);
        cfg_read(2'd2, rd); check("t1_status", rd, 16'h001B);
        ack_pulse(2);
        check("t1_en_after", 16'(interrupt_en), 16'h0000);
        cfg_read(2'd1, rd); check("t1_pend_after", rd, 16'h0000);

        // Test 2: simultaneous sources, lowest index first.
        pulse_irq(7'h22);
        wait_en("t2_en", 10);
        check("t2_num_first", 16'(interrupt_num), 16'h0002);
        interrupt_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("t2_en_during_ack", 16'(interrupt_en), 16'h0000);
        end
        interrupt_ack = 1'b0;
        cfg_read(2'd1, rd);
        check("t2_pend_left", rd,                 16'h0020);
        check("t2_en_drain",  16'(interrupt_en), 16'h0000);
        wait_en("t2_en_second", 10);
        check("t2_num_second", 16'(interrupt_num), 16'h0006);
        ack_pulse(2);

        // Test 3: masked source waits until unmasked.
        cfg_write(2'd0, 16'h0000);
        pulse_irq(7'h08);
        step(4);
        cfg_read(2'd1, rd);
        check("t3_pend",      rd,                 16'h0008);
        check("t3_en_masked", 16'(interrupt_en), 16'h0000);
        cfg_write(2'd0, 16'h0008);
        step(1);
        check("t3_en",  16'(interrupt_en),  16'h0001);
        check("t3_num", 16'(interrupt_num), 16'h0004);

        // Test 4: no pre-emption by a higher priority arrival.
        cfg_write(2'd0, 16'h007F);
        pulse_irq(7'h01);
        step(5);
        check("t4_num_held", 16'(interrupt_num), 16'h0004);
        cfg_read(2'd1, rd); check("t4_pend", rd, 16'h0009);
        ack_pulse(2);
        wait_en("t4_en_next", 10);
        check("t4_num_next", 16'(interrupt_num), 16'h0001);
        // W1C of the current source does not drop the request.
        cfg_write(2'd1, 16'h0001);
        check("t4_w1c_en", 16'(interrupt_en), 16'h0001);
        cfg_read(2'd1, rd); check("t4_w1c_pend", rd, 16'h0000);
        ack_pulse(2);
        step(3);
        check("t4_idle_en", 16'(interrupt_en), 16'h0000);

        // Test 5: held level serviced once.
        irq_in = 7'h40;
        wait_en("t5_en", 10);
        check("t5_num", 16'(interrupt_num), 16'h0007);
        ack_pulse(3);
        step(5);
        check("t5_no_retrig", 16'(interrupt_en), 16'h0000);
        cfg_read(2'd1, rd); check("t5_pend", rd, 16'h0000);
        irq_in = 7'h00;
        step(3);
        irq_in = 7'h40;
        wait_en("t5_retrig_en", 10);
        check("t5_retrig_num", 16'(interrupt_num), 16'h0007);
        ack_pulse(2);
        irq_in = 7'h00;
        step(4);

        // Test 6: reset mid-service, then a stray ack in IDLE.
        pulse_irq(7'h41);
        wait_en("t6_en", 10);
        check("t6_num", 16'(interrupt_num), 16'h0001);
        cfg_read(2'd1, rd); check("t6_pend", rd, 16'h0041);
        rst = 1'b0;
        step(1);
        check("t6_rst_en",  16'(interrupt_en),  16'h0000);
        check("t6_rst_num", 16'(interrupt_num), 16'h0000);
        rst = 1'b1;
        cfg_read(2'd2, rd); check("t6_status", rd, 16'h0000);
        cfg_read(2'd1, rd); check("t6_pend_clr", rd, 16'h0000);
        cfg_read(2'd0, rd); check("t6_mask_rst", rd, 16'h0000);
        interrupt_ack = 1'b1;
        step(2);
        interrupt_ack = 1'b0;
        step(3);
        check("t6_stray_en", 16'(interrupt_en), 16'h0000);
        cfg_read(2'd2, rd); check("t6_stray_status", rd, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
